serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple-carry adder: adds two WIDTH-bit operands plus carry-in, one bit per clock, using a single full-adder cell and a carry flip-flop. It is the additive counterpart of the team's 4-bit parallel borrow-ripple subtractor. It is intended for area-constrained datapaths where a full parallel adder is not justified. A start/busy/done handshake makes it drop-in for any sequencing FSM in the design.

## Interface
Parameters:
- WIDTH, 4, operand and sum width in bits (≥ 2).

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while the block is not in IDLE (ADD or DONE).
- done  output  1  one-cycle pulse; sum/cout/ovf are valid from this cycle on.
- sum  output  WIDTH  result a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states:
  - IDLE → ADD on start=1. Load shift registers opa←a, opb←b, set carry←cin, bit counter←0, clear the internal partial-sum shifter.
  - ADD: each cycle, compute s = opa[0]^opb[0]^carry and carry ← majority(opa[0], opb[0], carry). Shift opa and opb right by 1. Shift s into the MSB of the partial-sum shifter. Increment the counter.
    - On the cycle the counter reaches WIDTH-1, perform the final bit. Copy the partial sum into sum, the final carry into cout, and (carry-in of MSB)^(final carry) into ovf. Go to DONE.
  - DONE → IDLE unconditionally.
- done is high exactly in DONE.
- start is ignored in ADD and DONE. No queuing, and no effect on the in-flight operation.
- sum/cout/ovf change only at the ADD→DONE transition. They hold their value through IDLE until the next completion. Partial results are never visible on the outputs.
- Operands a/b/cin may change freely after the accepting cycle.
- Arithmetic: unsigned modulo 2^WIDTH. {cout,sum} equals the exact (WIDTH+1)-bit sum.
- Reset at any time, including mid-ADD or in DONE: next cycle is IDLE; sum, cout, ovf, busy, done = 0; internal registers cleared. The aborted operation produces no done.
- rst has priority over start in the same cycle.

## Timing
- start high in cycle 0 (IDLE) → busy high in cycles 1..WIDTH+1 → ADD in cycles 1..WIDTH → done high in cycle WIDTH+1 with results valid.
- Latency start→done: WIDTH+1 cycles.
- Earliest next start accepted: cycle WIDTH+2 (IDLE). Throughput: one operation per WIDTH+2 cycles.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0, state=IDLE.

## Structure
- Shared package serial_arith_pkg:
  - state enum {IDLE, ADD, DONE};
  - localparam counter width = $clog2(WIDTH);
  - intended for reuse by a future serial subtractor.
- Sub-module full_adder_cell: combinational 1-bit (a, b, ci) → (s, co). It is instantiated once.
- Top level holds the FSM, the operand and partial-sum shift registers, the carry FF, the counter, and the output registers.

## Test plan
- WIDTH=4, a=0x7, b=0x5, cin=0, start in cycle 0 → done in cycle 5 only; sum=0xC, cout=0, ovf=1; busy high in cycles 1–5.
- a=0xF, b=0x1, cin=0 → sum=0x0, cout=1, ovf=0. Then a=0xF, b=0xF, cin=1 → sum=0xF, cout=1, ovf=0.
- start held high continuously with changing a/b → only the operands at the accepting cycles are used; operations complete at cycles 5, 11, 17…; exactly one done per operation.
- Assert rst in cycle 2 of an operation (a=0x3, b=0x4) → cycle 3 shows IDLE, busy=0, sum=0, and no done. A subsequent start with a=0x3, b=0x4 → sum=0x7.
- Results hold: after done, keep start low for 20 cycles → sum/cout/ovf unchanged and done stays low.
- Randomized self-check, WIDTH=4 and WIDTH=8: 1000 operations → {cout,sum}==a+b+cin, and ovf matches the signed-overflow model.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM states and sizing helpers for bit-serial arithmetic blocks
package serial_arith_pkg;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int CNT_W = $clog2(DEF_WIDTH);
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: combinational 1-bit full adder
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple-carry adder, one bit per clock with a start/busy/done handshake
module serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = cnt_width(WIDTH);
  state_t state, state_nx;
  logic [WIDTH-1:0] opa, opb, psum, psum_nx;
  logic [CW-1:0] cnt;
  logic carry, s, co, last;
  full_adder_cell u_fa (.a(opa[0]), .b(opb[0]), .ci(carry), .s(s), .co(co));
  assign last    = cnt == CW'(WIDTH - 1);
  assign psum_nx = {s, psum[WIDTH-1:1]};
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ADD : IDLE;
      ADD:     state_nx = last ? DONE : ADD;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      opa   <= '0;
      opb   <= '0;
      psum  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == IDLE && start) begin
      opa   <= a;
      opb   <= b;
      carry <= cin;
      cnt   <= '0;
      psum  <= '0;
    end else if (state == ADD) begin
      opa   <= opa >> 1;
      opb   <= opb >> 1;
      carry <= co;
      psum  <= psum_nx;
      cnt   <= cnt + 1'b1;
      // carry still holds the carry into the MSB on the last bit
      if (last) begin
        sum  <= psum_nx;
        cout <= co;
        ovf  <= carry ^ co;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: vector table, corner sequences and randomized model check for serial_adder
module tb_serial_adder;
  logic clk = 0, rst = 1;
  logic start4 = 0, cin4 = 0, start8 = 0, cin8 = 0;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic busy4, done4, cout4, ovf4, busy8, done8, cout8, ovf8;
  int n_chk = 0, n_fail = 0;

  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));
  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b;
    logic       c;
    logic [3:0] s;
    logic       co, ov;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input int w, input int x, input int y, input int c,
                                output logic [7:0] s, output logic co, output logic ov);
    int total, sx, sy, ss, m;
    m = 1 << w;
    total = x + y + c;
    s = 8'(total % m);
    co = total >= m;
    sx = (x >= m / 2) ? x - m : x;
    sy = (y >= m / 2) ? y - m : y;
    ss = sx + sy + c;
    ov = (ss > m / 2 - 1) || (ss < -(m / 2));
  endfunction

  // Called at a negedge in IDLE; returns at the negedge of the done cycle (or on timeout).
  task automatic run_op(input int w, input logic [7:0] x, input logic [7:0] y, input logic c,
                        output logic [7:0] s, output logic co, output logic ov, output int lat);
    @(negedge clk);
    if (w == 4) begin start4 = 1; a4 = x[3:0]; b4 = y[3:0]; cin4 = c; end
    else begin start8 = 1; a8 = x; b8 = y; cin8 = c; end
    @(negedge clk);
    start4 = 0; start8 = 0;
    a4 = 4'($urandom); b4 = 4'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!((w == 4) ? done4 : done8) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s  = (w == 4) ? {4'h0, sum4} : sum8;
    co = (w == 4) ? cout4 : cout8;
    ov = (w == 4) ? ovf4 : ovf8;
  endtask

  initial begin
    logic [7:0] s, es;
    logic co, ov, eco, eov;
    int lat, x, y, c, dones;
    logic [3:0] qa[$], qb[$];
    logic qc[$];
    logic [3:0] hs;
    logic hco, hov;

    vecs[0] = '{4'h7, 4'h5, 1'b0, 4'hC, 1'b0, 1'b1};
    vecs[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
    vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
    vecs[4] = '{4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
    vecs[5] = '{4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1};
    vecs[6] = '{4'h8, 4'h7, 1'b1, 4'h0, 1'b1, 1'b0};
    vecs[7] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset busy4", busy4, 0);
    chk("reset done4", done4, 0);
    chk("reset sum4", sum4, 0);
    chk("reset cout4", cout4, 0);
    chk("reset ovf4", ovf4, 0);
    chk("reset busy8", busy8, 0);
    chk("reset sum8", sum8, 0);

    // cycle-accurate first operation: 7 + 5
    start4 = 1; a4 = 4'h7; b4 = 4'h5; cin4 = 0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start4 = 0; a4 = 4'hA; b4 = 4'h3;
      chk($sformatf("timing busy c%0d", cyc), busy4, cyc <= 5);
      chk($sformatf("timing done c%0d", cyc), done4, cyc == 5);
      if (cyc < 5) chk($sformatf("no partial sum c%0d", cyc), sum4, 0);
    end
    chk("7+5 sum", sum4, 4'hC);
    chk("7+5 cout", cout4, 0);
    chk("7+5 ovf", ovf4, 1);

    for (int i = 0; i < 8; i++) begin
      run_op(4, {4'h0, vecs[i].a}, {4'h0, vecs[i].b}, vecs[i].c, s, co, ov, lat);
      chk($sformatf("vec%0d latency", i), lat, 5);
      chk($sformatf("vec%0d sum", i), s, {4'h0, vecs[i].s});
      chk($sformatf("vec%0d cout", i), co, vecs[i].co);
      chk($sformatf("vec%0d ovf", i), ov, vecs[i].ov);
    end

    // start held high: accepts at cycles 0, 6, 12; completes at 5, 11, 17
    @(negedge clk);
    dones = 0;
    for (int cyc = 0; cyc <= 17; cyc++) begin
      if (cyc > 0) @(negedge clk);
      chk($sformatf("held done c%0d", cyc), done4, cyc % 6 == 5);
      if (done4 && qa.size() > 0) begin
        dones++;
        model(4, int'(qa[0]), int'(qb[0]), int'(qc[0]), es, eco, eov);
        chk("held sum", sum4, es[3:0]);
        chk("held cout", cout4, eco);
        chk("held ovf", ovf4, eov);
        void'(qa.pop_front()); void'(qb.pop_front()); void'(qc.pop_front());
      end
      start4 = 1; a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
      if (cyc % 6 == 0) begin qa.push_back(a4); qb.push_back(b4); qc.push_back(cin4); end
    end
    start4 = 0;
    chk("held done count", dones, 3);

    // reset in cycle 2 of 3 + 4
    @(negedge clk);
    start4 = 1; a4 = 4'h3; b4 = 4'h4; cin4 = 0;
    @(negedge clk); start4 = 0;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    chk("abort busy", busy4, 0);
    chk("abort done", done4, 0);
    chk("abort sum", sum4, 0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4) dones++;
    end
    chk("abort no done", dones, 0);
    run_op(4, 8'h3, 8'h4, 1'b0, s, co, ov, lat);
    chk("after abort sum", s, 8'h7);
    chk("after abort latency", lat, 5);

    // results hold while idle
    run_op(4, 8'h9, 8'h9, 1'b0, s, co, ov, lat);
    hs = s[3:0]; hco = co; hov = ov;
    chk("hold base", {hs, hco, hov}, {4'h2, 1'b1, 1'b1});
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done4) dones++;
      if (sum4 !== hs || cout4 !== hco || ovf4 !== hov) dones += 100;
    end
    chk("hold idle", dones, 0);

    for (int i = 0; i < 1000; i++) begin
      x = int'($urandom_range(15)); y = int'($urandom_range(15)); c = int'($urandom_range(1));
      run_op(4, 8'(x), 8'(y), 1'(c), s, co, ov, lat);
      model(4, x, y, c, es, eco, eov);
      chk("rand4 latency", lat, 5);
      chk($sformatf("rand4 %0h+%0h+%0d", x, y, c), {co, ov, s}, {eco, eov, es});
    end
    for (int i = 0; i < 1000; i++) begin
      x = int'($urandom_range(255)); y = int'($urandom_range(255)); c = int'($urandom_range(1));
      run_op(8, 8'(x), 8'(y), 1'(c), s, co, ov, lat);
      model(8, x, y, c, es, eco, eov);
      chk("rand8 latency", lat, 9);
      chk($sformatf("rand8 %0h+%0h+%0d", x, y, c), {co, ov, s}, {eco, eov, es});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
